// File: rtl/pong_match_sequencer.sv
// Match-level control for a pong game: serve timing, goal scoring, rally speed-up
// and win detection, with every output registered on game_clk.
module pong_match_sequencer #(
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_DELAY   = 60,
    parameter int GOAL_MARGIN   = 4,
    parameter int VEL_INIT      = 2,
    parameter int VEL_MAX       = 6,
    parameter int HITS_PER_STEP = 4
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause,
    input  logic       paddle_hit,
    input  logic [9:0] x_ball,
    input  logic [4:0] width_ball,
    input  logic [9:0] x_lwall,
    input  logic [9:0] x_rwall,
    output logic       ball_load,
    output logic       ball_run,
    output logic       serve_dir,
    output logic [3:0] ball_vel,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    localparam logic [3:0]  WIN_V      = 4'(WIN_SCORE);
    localparam logic [9:0]  DELAY_LOAD = 10'(SERVE_DELAY - 1);
    localparam logic [10:0] MARGIN_V   = 11'(GOAL_MARGIN);
    localparam logic [3:0]  VEL_INIT_V = 4'(VEL_INIT);
    localparam logic [3:0]  VEL_MAX_V  = 4'(VEL_MAX);
    localparam logic [3:0]  HITS_LAST  = 4'(HITS_PER_STEP - 1);

    state_t      state_r;
    logic        start_q_r;
    logic [9:0]  delay_cnt_r;
    logic [3:0]  hit_cnt_r;

    logic        start_edge_s;
    logic        left_goal_s;
    logic        right_goal_s;

    assign start_edge_s = start_btn & ~start_q_r;
    // Widened to 11 bits so wall + margin and ball + width + margin cannot wrap.
    assign left_goal_s  = {1'b0, x_ball} < ({1'b0, x_lwall} + MARGIN_V);
    assign right_goal_s = ({1'b0, x_ball} + {6'd0, width_ball} + MARGIN_V) > {1'b0, x_rwall};

    // Match state machine; all outputs are updated here so they are registered.
    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            start_q_r   <= 1'b0;
            delay_cnt_r <= 10'd0;
            hit_cnt_r   <= 4'd0;
            ball_load   <= 1'b1;
            ball_run    <= 1'b0;
            serve_dir   <= 1'b1;
            ball_vel    <= VEL_INIT_V;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            start_q_r <= start_btn;
            case (state_r)
                IDLE, GAME_OVER: begin
                    if (start_edge_s) begin
                        state_r     <= SERVE_WAIT;
                        score_l     <= 4'd0;
                        score_r     <= 4'd0;
                        ball_vel    <= VEL_INIT_V;
                        hit_cnt_r   <= 4'd0;
                        serve_dir   <= 1'b1;
                        delay_cnt_r <= DELAY_LOAD;
                        ball_load   <= 1'b1;
                        ball_run    <= 1'b0;
                        game_over   <= 1'b0;
                        winner      <= 1'b0;
                    end
                end
                SERVE_WAIT: begin
                    if (delay_cnt_r == 10'd0) begin
                        state_r   <= PLAY;
                        ball_load <= 1'b0;
                        ball_run  <= ~pause;
                    end else begin
                        delay_cnt_r <= delay_cnt_r - 10'd1;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        ball_run <= 1'b0;
                    end else if (left_goal_s) begin
                        // Left goal wins a tie and swallows any coincident paddle hit.
                        if (score_r < WIN_V) score_r <= score_r + 4'd1;
                        serve_dir <= 1'b0;
                        state_r   <= POINT;
                        ball_run  <= 1'b0;
                        ball_load <= 1'b1;
                    end else if (right_goal_s) begin
                        if (score_l < WIN_V) score_l <= score_l + 4'd1;
                        serve_dir <= 1'b1;
                        state_r   <= POINT;
                        ball_run  <= 1'b0;
                        ball_load <= 1'b1;
                    end else begin
                        ball_run <= 1'b1;
                        if (paddle_hit) begin
                            if (hit_cnt_r >= HITS_LAST) begin
                                hit_cnt_r <= 4'd0;
                                if (ball_vel < VEL_MAX_V) ball_vel <= ball_vel + 4'd1;
                            end else begin
                                hit_cnt_r <= hit_cnt_r + 4'd1;
                            end
                        end
                    end
                end
                POINT: begin
                    ball_run <= 1'b0;
                    if ((score_l == WIN_V) || (score_r == WIN_V)) begin
                        state_r   <= GAME_OVER;
                        game_over <= 1'b1;
                        winner    <= (score_r == WIN_V);
                        ball_load <= 1'b0;
                    end else begin
                        state_r     <= SERVE_WAIT;
                        ball_vel    <= VEL_INIT_V;
                        hit_cnt_r   <= 4'd0;
                        delay_cnt_r <= DELAY_LOAD;
                        ball_load   <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    ball_load <= 1'b1;
                    ball_run  <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Self-checking bench for pong_match_sequencer: table-driven PLAY vectors plus
// hand-written serve, scoring, game-over and reset sequences through a scoreboard.
module tb_pong_match_sequencer;

    logic       game_clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       pause;
    logic       paddle_hit;
    logic [9:0] x_ball;
    logic [4:0] width_ball;
    logic [9:0] x_lwall;
    logic [9:0] x_rwall;
    logic       ball_load;
    logic       ball_run;
    logic       serve_dir;
    logic [3:0] ball_vel;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        pause;
        logic        hit;
        logic [9:0]  xb;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[26];

    pong_match_sequencer dut (
        .game_clk   (game_clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .pause      (pause),
        .paddle_hit (paddle_hit),
        .x_ball     (x_ball),
        .width_ball (width_ball),
        .x_lwall    (x_lwall),
        .x_rwall    (x_rwall),
        .ball_load  (ball_load),
        .ball_run   (ball_run),
        .serve_dir  (serve_dir),
        .ball_vel   (ball_vel),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 game_clk = ~game_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] o(input logic ld, input logic rn, input logic dr,
                                      input int vel, input int sl, input int sr,
                                      input logic go, input logic wn);
        return {ld, rn, dr, 4'(vel), 4'(sl), 4'(sr), go, wn};
    endfunction

    // Pop the oldest expectation and compare it with the current DUT outputs.
    task automatic check_out();
        sb_t         e;
        logic [16:0] got;
        got = {ball_load, ball_run, serve_dir, ball_vel, score_l, score_r, game_over, winner};
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: empty queue, got=%h", got);
            return;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (got === e.exp) n_pass++;
        else $display("FAIL %s: got load=%b run=%b dir=%b vel=%0d sl=%0d sr=%0d go=%b win=%b, expected load=%b run=%b dir=%b vel=%0d sl=%0d sr=%0d go=%b win=%b",
                      e.tag, got[16], got[15], got[14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                      e.exp[16], e.exp[15], e.exp[14], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
    endtask

    task automatic step(input string tag, input logic [16:0] exp);
        sb_q.push_back('{tag, exp});
        @(posedge game_clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input string tag, input logic [16:0] exp);
        sb_q.push_back('{tag, exp});
        check_out();
    endtask

    // The serve hold lasts 60 cycles from its entry edge, which the caller has already stepped.
    task automatic serve_wait(input logic dir, input int sl, input int sr, input logic pause_mid);
        for (int i = 1; i < 60; i++) begin
            pause = pause_mid && (i >= 10) && (i < 20);
            step("serve_hold", o(1'b1, 1'b0, dir, 2, sl, sr, 1'b0, 1'b0));
        end
        pause = 1'b0;
        step("serve_release", o(1'b0, 1'b1, dir, 2, sl, sr, 1'b0, 1'b0));
    endtask

    initial begin
        // PLAY vectors: pause masking, 20 paddle hits, paused goal, then left goal.
        tbl[0] = '{1'b0, 1'b0, 10'd300, o(1'b0, 1'b1, 1'b1, 2, 0, 0, 1'b0, 1'b0)};
        tbl[1] = '{1'b1, 1'b1, 10'd300, o(1'b0, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0)};
        for (int k = 1; k <= 20; k++) begin
            tbl[1 + k] = '{1'b0, 1'b1, 10'd300,
                           o(1'b0, 1'b1, 1'b1, 2 + ((k / 4) > 4 ? 4 : (k / 4)), 0, 0, 1'b0, 1'b0)};
        end
        tbl[22] = '{1'b0, 1'b0, 10'd300, o(1'b0, 1'b1, 1'b1, 6, 0, 0, 1'b0, 1'b0)};
        tbl[23] = '{1'b1, 1'b0, 10'd11,  o(1'b0, 1'b0, 1'b1, 6, 0, 0, 1'b0, 1'b0)};
        tbl[24] = '{1'b0, 1'b1, 10'd11,  o(1'b1, 1'b0, 1'b0, 6, 0, 1, 1'b0, 1'b0)};
        tbl[25] = '{1'b0, 1'b0, 10'd300, o(1'b1, 1'b0, 1'b0, 2, 0, 1, 1'b0, 1'b0)};

        reset = 1'b1; start_btn = 1'b0; pause = 1'b0; paddle_hit = 1'b0;
        x_ball = 10'd300; width_ball = 5'd8; x_lwall = 10'd8; x_rwall = 10'd600;
        #2;
        reset = 1'b0;
        #1;
        check_now("reset_async", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));
        repeat (2) @(posedge game_clk);
        #1;
        reset = 1'b1;
        step("idle", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));

        start_btn = 1'b1;
        step("start", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));
        serve_wait(1'b1, 0, 0, 1'b1);

        for (int i = 0; i < 26; i++) begin
            pause      = tbl[i].pause;
            paddle_hit = tbl[i].hit;
            x_ball     = tbl[i].xb;
            step($sformatf("vec%0d", i), tbl[i].exp);
        end
        paddle_hit = 1'b0;
        serve_wait(1'b0, 0, 1, 1'b0);

        // Start edges during PLAY must not restart the match.
        start_btn = 1'b0;
        step("start_low_play", o(1'b0, 1'b1, 1'b0, 2, 0, 1, 1'b0, 1'b0));
        start_btn = 1'b1;
        step("start_ignored", o(1'b0, 1'b1, 1'b0, 2, 0, 1, 1'b0, 1'b0));
        start_btn = 1'b0;

        // Both goal conditions at once: left goal only.
        x_ball = 10'd11; x_rwall = 10'd20;
        step("both_goals", o(1'b1, 1'b0, 1'b0, 2, 0, 2, 1'b0, 1'b0));
        x_ball = 10'd300; x_rwall = 10'd600;
        step("point_after_both", o(1'b1, 1'b0, 1'b0, 2, 0, 2, 1'b0, 1'b0));
        serve_wait(1'b0, 0, 2, 1'b0);

        for (int k = 1; k <= 7; k++) begin
            x_ball = 10'd590;
            step($sformatf("right_goal%0d", k), o(1'b1, 1'b0, 1'b1, 2, k, 2, 1'b0, 1'b0));
            x_ball = 10'd300;
            if (k < 7) begin
                step($sformatf("point%0d", k), o(1'b1, 1'b0, 1'b1, 2, k, 2, 1'b0, 1'b0));
                serve_wait(1'b1, k, 2, 1'b0);
            end else begin
                step("game_over", o(1'b0, 1'b0, 1'b1, 2, 7, 2, 1'b1, 1'b0));
            end
        end
        step("game_over_hold", o(1'b0, 1'b0, 1'b1, 2, 7, 2, 1'b1, 1'b0));

        start_btn = 1'b1;
        step("restart", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));
        serve_wait(1'b1, 0, 0, 1'b0);
        start_btn = 1'b0;

        // Reset mid-PLAY with a paddle hit pending takes effect without a clock edge.
        paddle_hit = 1'b1;
        x_ball = 10'd590;
        #3;
        reset = 1'b0;
        #1;
        check_now("reset_mid_play", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));
        @(posedge game_clk);
        #1;
        check_now("reset_held", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));
        paddle_hit = 1'b0;
        x_ball = 10'd300;
        reset = 1'b1;
        step("idle_after_reset", o(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_match_sequencer.md
PONG_MATCH_SEQUENCER -- requirements
Module: pong_match_sequencer

Interface
REQ-001 SHALL provide parameter WIN_SCORE, default 7, points needed to win a match (1..15).
REQ-002 SHALL provide parameter SERVE_DELAY, default 60, game ticks the ball is held at centre before each serve (1..1023).
REQ-003 SHALL provide parameter GOAL_MARGIN, default 4, pixel tolerance added/subtracted at the side walls for goal detection.
REQ-004 SHALL provide parameters VEL_INIT (default 2), VEL_MAX (default 6), HITS_PER_STEP (default 4): serve speed, speed cap, paddle hits per speed increment.
REQ-005 game_clk  in  1  game tick clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; one clock domain only.
REQ-007 start_btn  in  1  level, synchronous to game_clk; rising edge starts a match.
REQ-008 pause  in  1  level; freezes play while high.
REQ-009 paddle_hit  in  1  one-cycle pulse from paddle collision logic.
REQ-010 x_ball  in  10  current ball left-edge x position.
REQ-011 width_ball  in  5  ball width in pixels.
REQ-012 x_lwall, x_rwall  in  10 each  playfield side walls.
REQ-013 ball_load  out  1  high = ball datapath held at centre (200,200).
REQ-014 ball_run  out  1  high = ball datapath advances this tick.
REQ-015 serve_dir  out  1  initial x direction for next serve; 1 = increasing x.
REQ-016 ball_vel  out  4  x velocity magnitude for the ball datapath.
REQ-017 score_l, score_r  out  4 each  player scores.
REQ-018 game_over  out  1  high while match finished; winner  out  1  0 = left, 1 = right, valid when game_over.

Function
REQ-019 All outputs SHALL be registered; a decision on inputs sampled at edge N SHALL appear on outputs after edge N.
REQ-020 FSM states SHALL be IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER.
REQ-021 Start edge SHALL be detected from a registered copy of start_btn; a held-high start_btn SHALL count once.
REQ-022 IDLE: ball_load=1, ball_run=0; on start edge -> SERVE_WAIT, scores=0, ball_vel=VEL_INIT, hit count=0, serve_dir=1, delay counter loaded.
REQ-023 SERVE_WAIT: ball_load=1, ball_run=0; SHALL last exactly SERVE_DELAY cycles, then -> PLAY; pause SHALL NOT stretch it.
REQ-024 PLAY: ball_load=0, ball_run = ~pause; while pause high, goal detection and paddle_hit SHALL be ignored.
REQ-025 Left goal: x_ball < x_lwall + GOAL_MARGIN (11-bit compare) -> score_r+1, serve_dir=0, -> POINT.
REQ-026 Right goal: x_ball + width_ball + GOAL_MARGIN > x_rwall (11-bit compare) -> score_l+1, serve_dir=1, -> POINT.
REQ-027 Both goal conditions in one cycle SHALL award the left goal only.
REQ-028 paddle_hit in PLAY SHALL increment the hit counter; on reaching HITS_PER_STEP the counter SHALL clear and ball_vel SHALL increment, saturating at VEL_MAX.
REQ-029 paddle_hit coincident with a goal SHALL be ignored.
REQ-030 POINT: one cycle, ball_run=0, ball_load=1; if either score == WIN_SCORE -> GAME_OVER with winner set, else -> SERVE_WAIT with ball_vel=VEL_INIT, hit count=0, delay reloaded.
REQ-031 GAME_OVER: ball_run=0, ball_load=0, game_over=1, scores held; start edge SHALL behave as in IDLE (REQ-022).
REQ-032 Start edges outside IDLE/GAME_OVER SHALL be ignored.
REQ-033 Scores SHALL never exceed WIN_SCORE.

Reset
REQ-034 reset low SHALL immediately force IDLE, ball_load=1, ball_run=0, serve_dir=1, ball_vel=VEL_INIT, scores=0, game_over=0, winner=0, counters=0, start history=0.
REQ-035 Reset asserted mid-SERVE_WAIT or mid-PLAY SHALL abandon the match; no score update SHALL occur.

Verification
REQ-036 Reset, start pulse -> ball_load=1 for exactly 60 cycles, then ball_run=1, ball_vel=2, serve_dir=1.
REQ-037 PLAY, x_lwall=8, x_ball=11 -> next cycle score_r=1, serve_dir=0, POINT for one cycle, then SERVE_WAIT.
REQ-038 PLAY, 20 paddle_hit pulses -> ball_vel steps 2,3,4,5,6 and stays 6; goal then resets it to 2.
REQ-039 score_l=6, right goal -> score_l=7, game_over=1, winner=0; next start edge -> scores 0, SERVE_WAIT.
REQ-040 PLAY with pause high and x_ball at left goal -> ball_run=0, no score change; pause low -> left goal scored next cycle.
REQ-041 reset pulsed low during PLAY with paddle_hit high -> all outputs at REQ-034 values, no clock edge required.
